// File: rtl/dmem_responder.sv
// Purpose : word-addressed data memory answering CPU LW/SW accesses over a four-phase req/ack handshake.
// Latency : ack rises WAIT_CYCLES+1 edges after the request is accepted; turnaround is WAIT_CYCLES+3 edges.
// Backpress: one access in flight; a new request is taken only in IDLE, after req has been seen low.
//
// Ports:
//   clock, resetn        single clock, synchronous active-low reset
//   req, we, addr, wdata request from the memory stage; we/addr/wdata latched on acceptance
//   rdata, ack, err      registered response, valid while ack=1 (rdata keeps its value afterwards)
//   busy                 high whenever an access is in flight or being acknowledged
module dmem_responder #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  req,
    input  logic                  we,
    input  logic [15:0]           addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ack,
    output logic                  err,
    output logic                  busy
);

    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic                    lwe;
    logic [15:0]             laddr;
    logic [DATA_WIDTH-1:0]   lwdata;

    logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];

    logic                    fault;
    logic                    commit;
    logic [ADDR_WIDTH-1:0]   widx;

    // Misaligned, or any byte-address bit above the word index set: outside the array.
    assign fault  = laddr[0] | ((laddr >> (ADDR_WIDTH + 1)) != 16'd0);
    assign widx   = laddr[ADDR_WIDTH:1];
    assign commit = (state == S_WAIT) && (cnt == 4'd0);
    assign busy   = (state != S_IDLE);

    // Handshake FSM with registered response outputs.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state  <= S_IDLE;
            cnt    <= 4'd0;
            ack    <= 1'b0;
            err    <= 1'b0;
            rdata  <= '0;
            lwe    <= 1'b0;
            laddr  <= 16'd0;
            lwdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        lwe    <= we;
                        laddr  <= addr;
                        lwdata <= wdata;
                        cnt    <= WAIT_INIT;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        ack   <= 1'b1;
                        state <= S_ACK;
                        if (fault) begin
                            rdata <= '0;
                            err   <= 1'b1;
                        end else if (!lwe) begin
                            rdata <= mem[widx];
                        end
                    end
                end
                S_ACK: begin
                    // Wait for req to drop; this is what stops a held req from re-triggering.
                    if (!req) begin
                        ack   <= 1'b0;
                        err   <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Storage is never cleared; the resetn term stops a store aborted by reset at its commit edge.
    always_ff @(posedge clock) begin
        if (resetn && commit && lwe && !fault) begin
            mem[widx] <= lwdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int W     = 2;
    localparam int DEPTH = 256;

    logic        clock = 1'b0;
    logic        resetn;
    logic        req, we;
    logic [15:0] addr, wdata;
    logic [15:0] rdata;
    logic        ack, err, busy;

    logic        req0, we0;
    logic [15:0] addr0, wdata0;
    logic [15:0] rdata0;
    logic        ack0, err0, busy0;

    always #5 clock = ~clock;

    dmem_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .WAIT_CYCLES(W)) dut (
        .clock(clock), .resetn(resetn), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .err(err), .busy(busy)
    );

    dmem_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut0 (
        .clock(clock), .resetn(resetn), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: word array plus "was written" flags and last returned data.
    logic [15:0] mem_m   [DEPTH];
    bit          known_m [DEPTH];
    logic [15:0] last_rd = 16'h0;

    function automatic bit fault_m(input logic [15:0] a);
        return (a % 2 != 0) || (int'(a) >= 2 * DEPTH);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Full four-phase access on the WAIT_CYCLES=2 instance. Called just after a negedge.
    task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] exp_rd, input logic exp_err, input int hold,
                          input bit scramble, input bit drop, input string name);
        int k;
        bit got;
        we = w; addr = a; wdata = d; req = 1'b1;
        @(posedge clock); @(negedge clock);
        chk({name, " busy after accept"}, {31'd0, busy}, 32'd1);
        chk({name, " no early ack"}, {31'd0, ack}, 32'd0);
        if (drop) req = 1'b0;
        k = 0; got = 0;
        while (!got && k < 40) begin
            if (scramble) begin
                addr = 16'($urandom); wdata = 16'($urandom); we = 1'($urandom);
            end
            @(posedge clock); k++;
            @(negedge clock);
            if (ack) got = 1;
        end
        chk({name, " ack latency"}, k, W + 1);
        chk({name, " rdata"}, {16'd0, rdata}, {16'd0, exp_rd});
        chk({name, " err"}, {31'd0, err}, {31'd0, exp_err});
        for (int h = 0; h < hold; h++) begin
            @(posedge clock); @(negedge clock);
            chk({name, " held ack/busy/err/rdata"}, {13'd0, ack, busy, err, rdata},
                {13'd0, 1'b1, 1'b1, exp_err, exp_rd});
        end
        req = 1'b0;
        @(posedge clock); @(negedge clock);
        chk({name, " release ack/err/busy"}, {29'd0, ack, err, busy}, 32'd0);
        chk({name, " rdata kept"}, {16'd0, rdata}, {16'd0, exp_rd});
        if (w && !fault_m(a)) begin
            mem_m[a / 2]   = d;
            known_m[a / 2] = 1'b1;
        end
        last_rd = exp_rd;
    endtask

    // Access on the zero-wait instance: ack must be up one edge after acceptance.
    task automatic access0(input logic w, input logic [15:0] a, input logic [15:0] d,
                           input logic [15:0] exp_rd, input string name);
        we0 = w; addr0 = a; wdata0 = d; req0 = 1'b1;
        @(posedge clock); @(negedge clock);
        chk({name, " ack/busy after accept"}, {30'd0, ack0, busy0}, 32'd1);
        @(posedge clock); @(negedge clock);
        chk({name, " ack/err one edge later"}, {30'd0, ack0, err0}, 32'd2);
        chk({name, " rdata"}, {16'd0, rdata0}, {16'd0, exp_rd});
        req0 = 1'b0;
        @(posedge clock); @(negedge clock);
        chk({name, " release"}, {30'd0, ack0, busy0}, 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        logic        exp_err;
        int          hold;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic        rw;
        logic [15:0] ra, rd_e;
        logic        re_e;
        int          sel;

        tbl[0] = '{1'b1, 16'h0004, 16'hBEEF, 16'h0000, 1'b0, 0};
        tbl[1] = '{1'b0, 16'h0004, 16'h0000, 16'hBEEF, 1'b0, 4};
        tbl[2] = '{1'b1, 16'h0000, 16'h1234, 16'hBEEF, 1'b0, 0};
        tbl[3] = '{1'b1, 16'h0001, 16'hDEAD, 16'h0000, 1'b1, 0};
        tbl[4] = '{1'b1, 16'h0200, 16'hDEAD, 16'h0000, 1'b1, 1};
        tbl[5] = '{1'b0, 16'h0000, 16'h0000, 16'h1234, 1'b0, 0};
        tbl[6] = '{1'b1, 16'h01FE, 16'hA5A5, 16'h1234, 1'b0, 0};
        tbl[7] = '{1'b0, 16'h01FE, 16'h0000, 16'hA5A5, 1'b0, 0};

        for (int i = 0; i < DEPTH; i++) known_m[i] = 1'b0;

        // Reset with req already high; first edge after release must accept.
        resetn = 1'b0; req = 1'b1; we = 1'b1; addr = 16'h0010; wdata = 16'hCAFE;
        req0 = 1'b0; we0 = 1'b0; addr0 = 16'h0; wdata0 = 16'h0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset ack/err/busy", {29'd0, ack, err, busy}, 32'd0);
        chk("reset rdata", {16'd0, rdata}, 32'd0);
        chk("reset dut0 outputs", {13'd0, ack0, err0, busy0, rdata0}, 32'd0);
        resetn = 1'b1;
        access(1'b1, 16'h0010, 16'hCAFE, 16'h0000, 1'b0, 0, 0, 0, "first after reset");

        for (int i = 0; i < 8; i++)
            access(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd, tbl[i].exp_err,
                   tbl[i].hold, 0, 0, $sformatf("vec%0d", i));

        // Inputs scrambled during WAIT must not affect the latched store.
        access(1'b1, 16'h000A, 16'h7777, last_rd, 1'b0, 0, 0, 0, "preload A");
        access(1'b1, 16'h0008, 16'h1111, last_rd, 1'b0, 0, 1, 0, "scrambled SW 8");
        access(1'b0, 16'h0008, 16'h0000, 16'h1111, 1'b0, 0, 0, 0, "LW 8 after scramble");
        access(1'b0, 16'h000A, 16'h0000, 16'h7777, 1'b0, 0, 0, 0, "LW A untouched");

        // Reset during WAIT aborts the store.
        access(1'b1, 16'h0006, 16'h3333, last_rd, 1'b0, 0, 0, 0, "preload 6");
        we = 1'b1; addr = 16'h0006; wdata = 16'h5555; req = 1'b1;
        @(posedge clock); @(negedge clock);
        chk("midreset busy before", {31'd0, busy}, 32'd1);
        resetn = 1'b0; req = 1'b0;
        @(posedge clock); @(negedge clock);
        chk("midreset outputs", {13'd0, ack, err, busy, rdata}, 32'd0);
        resetn = 1'b1;
        @(posedge clock); @(negedge clock);
        last_rd = 16'h0;
        access(1'b0, 16'h0006, 16'h0000, 16'h3333, 1'b0, 0, 0, 0, "LW 6 after abort");

        // req dropped during WAIT: access still completes, ack then falls.
        access(1'b0, 16'h0004, 16'h0000, 16'hBEEF, 1'b0, 0, 0, 1, "req dropped in WAIT");

        // Zero wait states.
        access0(1'b1, 16'h0002, 16'h0F0F, 16'h0000, "w0 SW 2");
        access0(1'b0, 16'h0002, 16'h0000, 16'h0F0F, "w0 LW 2");

        // Randomized accesses against the model.
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      ra = 16'($urandom) | 16'h0001;
            else if (sel == 1) ra = (16'($urandom) | 16'h0200) & 16'hFFFE;
            else               ra = 16'(2 * $urandom_range(32, 47));
            rw = 1'($urandom);
            if (!rw && !fault_m(ra) && !known_m[ra / 2]) rw = 1'b1;
            if (fault_m(ra))   begin rd_e = 16'h0;          re_e = 1'b1; end
            else if (rw)       begin rd_e = last_rd;        re_e = 1'b0; end
            else               begin rd_e = mem_m[ra / 2];  re_e = 1'b0; end
            access(rw, ra, 16'($urandom), rd_e, re_e, $urandom_range(0, 2), 1, 0,
                   $sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
